udp_tx_payload_framer: RTL and testbench



---
 rtl/udp_tx_payload_framer_if.sv | 28 ++
 rtl/udp_tx_payload_framer.sv | 143 ++++++++++++++
 tb/tb_udp_tx_payload_framer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_tx_payload_framer_if.sv
// FIFO snoop/read, flush and UDP transmit handshake signals shared by the payload framer
// (master) and its environment (slave).
interface udp_tx_payload_framer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_wr_en;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  flush;
  logic                  udp_tx_req;
  logic [15:0]           udp_tx_len;
  logic                  udp_tx_ack;
  logic [DATA_WIDTH-1:0] udp_tx_data;
  logic                  udp_tx_valid;
  logic                  busy;

  modport master (
    input  fifo_wr_en, fifo_full, fifo_empty, fifo_rd_data, flush, udp_tx_ack,
    output fifo_rd_en, udp_tx_req, udp_tx_len, udp_tx_data, udp_tx_valid, busy
  );

  modport slave (
    output fifo_wr_en, fifo_full, fifo_empty, fifo_rd_data, flush, udp_tx_ack,
    input  fifo_rd_en, udp_tx_req, udp_tx_len, udp_tx_data, udp_tx_valid, busy
  );
endinterface

// File: rtl/udp_tx_payload_framer.sv
// Drains fixed-size (or flushed partial) payloads from the UDP tx FIFO into the UDP core,
// tracking FIFO occupancy by snooping accepted writes and issued reads.
module udp_tx_payload_framer #(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int PAYLOAD_LEN = 32,
  parameter int RD_LATENCY  = 1,
  parameter int ACK_TIMEOUT = 1023,
  parameter int IFG_CYCLES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  udp_tx_payload_framer_if.master bus
);

  localparam int LVL_W   = ADDR_WIDTH + 1;
  localparam int CNT_MAX = (ACK_TIMEOUT > IFG_CYCLES) ? ACK_TIMEOUT : IFG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_READ, S_GAP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LVL_W-1:0]      r_level;
  logic                  r_flush_pending;
  logic [15:0]           r_len;
  logic [15:0]           r_remaining;
  logic [CNT_W-1:0]      r_cnt;
  logic [RD_LATENCY-1:0] r_vld_p;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  logic w_wr_acc;
  logic w_rd_en;
  logic w_full_pkt;
  logic w_flush_pkt;
  logic w_enter_req;
  logic w_start_read;
  logic w_timeout;
  logic w_gap_done;
  logic w_read_done;

  assign w_wr_acc    = bus.fifo_wr_en && !bus.fifo_full;
  assign w_full_pkt  = (r_level >= LVL_W'(PAYLOAD_LEN));
  assign w_flush_pkt = r_flush_pending && (r_level != '0);
  assign w_timeout   = (r_cnt == CNT_W'(ACK_TIMEOUT - 1));
  assign w_gap_done  = (r_cnt == CNT_W'(IFG_CYCLES - 1));
  assign w_read_done = (r_remaining == '0) && (r_vld_p == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rd_en      = 1'b0;
    w_enter_req  = 1'b0;
    w_start_read = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_full_pkt || w_flush_pkt) begin
          w_state_nxt = S_REQ;
          w_enter_req = 1'b1;
        end
      end
      S_REQ: begin
        // An ack arriving on the last wait cycle still wins over the timeout.
        if (bus.udp_tx_ack) begin
          w_state_nxt  = S_READ;
          w_start_read = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_GAP;
        end
      end
      S_READ: begin
        w_rd_en = !bus.fifo_empty && (r_remaining != '0);
        if (w_read_done) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (w_gap_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shared wait/gap counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst)                                      r_cnt <= '0;
    else if (w_state_nxt != r_state)              r_cnt <= '0;
    else if (r_state == S_REQ || r_state == S_GAP) r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level         <= '0;
      r_flush_pending <= 1'b0;
      r_len           <= '0;
      r_remaining     <= '0;
    end else begin
      if (w_wr_acc && !w_rd_en)      r_level <= r_level + LVL_W'(1);
      else if (!w_wr_acc && w_rd_en) r_level <= r_level - LVL_W'(1);

      if (w_enter_req)                               r_flush_pending <= 1'b0;
      else if (bus.flush)                            r_flush_pending <= 1'b1;
      else if (r_state == S_IDLE && r_level == '0)   r_flush_pending <= 1'b0;

      if (w_enter_req) r_len <= w_full_pkt ? 16'(PAYLOAD_LEN) : 16'(r_level);

      if (w_start_read)  r_remaining <= r_len;
      else if (w_rd_en)  r_remaining <= r_remaining - 16'd1;
    end
  end

  // Stage p0..pN: valid shift pipe aligned with the FIFO read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= w_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) r_vld_p[i] <= r_vld_p[i-1];
    end
  end

  // Output stage: capture FIFO data at the pipe tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= r_vld_p[RD_LATENCY-1];
      if (r_vld_p[RD_LATENCY-1]) r_data <= bus.fifo_rd_data;
    end
  end

  assign bus.fifo_rd_en   = w_rd_en;
  assign bus.udp_tx_req   = (r_state == S_REQ);
  assign bus.udp_tx_len   = r_len;
  assign bus.udp_tx_data  = r_data;
  assign bus.udp_tx_valid = r_valid;
  assign bus.busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_udp_tx_payload_framer.sv
// Scoreboard bench: three framer instances (default, RD_LATENCY=2, ACK_TIMEOUT=16), each fed by
// a behavioural FIFO; expected payload bytes are queued by stimulus and popped by a monitor.
module tb_udp_tx_payload_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_d     [3];
  logic       wr_en_d   [3];
  logic [7:0] wr_data_d [3];
  logic       flush_d   [3];
  logic       ack_d     [3];

  logic        req_w   [3];
  logic        valid_w [3];
  logic        busy_w  [3];
  logic        rd_w    [3];
  logic [15:0] len_w   [3];
  logic [7:0]  data_w  [3];
  logic [7:0]  lvl_w   [3];
  logic [1:0]  st_w    [3];
  int          rd_cnt_w   [3];
  int          req_rise_w [3];

  logic [7:0] exp_q [3][$];
  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int RDL  = (g == 1) ? 2 : 1;
    localparam int ACKT = (g == 2) ? 16 : 1023;

    udp_tx_payload_framer_if #(.DATA_WIDTH(8)) bus ();

    udp_tx_payload_framer #(
      .RD_LATENCY (RDL),
      .ACK_TIMEOUT(ACKT)
    ) u_dut (
      .clk(clk),
      .rst(rst_d[g]),
      .bus(bus)
    );

    logic [7:0] mem [128];
    logic [7:0] wp = 8'd0;
    logic [7:0] rp = 8'd0;
    logic [7:0] d1 = 8'd0;
    logic [7:0] d2 = 8'd0;
    logic       req_q = 1'b0;
    int         rd_cnt = 0;
    int         req_rise = 0;

    assign bus.fifo_wr_en   = wr_en_d[g];
    assign bus.flush        = flush_d[g];
    assign bus.udp_tx_ack   = ack_d[g];
    assign bus.fifo_full    = ((wp - rp) == 8'd128);
    assign bus.fifo_empty   = (wp == rp);
    assign bus.fifo_rd_data = (RDL == 1) ? d1 : d2;

    always @(posedge clk) begin
      if (rst_d[g]) begin
        wp <= 8'd0; rp <= 8'd0; d1 <= 8'd0; d2 <= 8'd0;
      end else begin
        if (bus.fifo_wr_en && !bus.fifo_full) begin
          mem[wp[6:0]] <= wr_data_d[g];
          wp <= wp + 8'd1;
        end
        if (bus.fifo_rd_en && !bus.fifo_empty) begin
          d1 <= mem[rp[6:0]];
          rp <= rp + 8'd1;
        end
        d2 <= d1;
      end
    end

    always @(posedge clk) begin
      if (bus.fifo_rd_en) rd_cnt <= rd_cnt + 1;
      if (bus.udp_tx_req && !req_q) req_rise <= req_rise + 1;
      req_q <= bus.udp_tx_req;
    end

    assign req_w[g]      = bus.udp_tx_req;
    assign valid_w[g]    = bus.udp_tx_valid;
    assign busy_w[g]     = bus.busy;
    assign rd_w[g]       = bus.fifo_rd_en;
    assign len_w[g]      = bus.udp_tx_len;
    assign data_w[g]     = bus.udp_tx_data;
    assign lvl_w[g]      = u_dut.r_level;
    assign st_w[g]       = u_dut.r_state;
    assign rd_cnt_w[g]   = rd_cnt;
    assign req_rise_w[g] = req_rise;
  end

  task automatic chk(input int k, input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %0d expected %0d", name, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int k);
    step();
    rst_d[k] = 1'b1; wr_en_d[k] = 1'b0; flush_d[k] = 1'b0; ack_d[k] = 1'b0;
    repeat (2) step();
    rst_d[k] = 1'b0;
  endtask

  task automatic write_seq(input int k, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en_d[k] = 1'b1;
      wr_data_d[k] = 8'(first + i);
      step();
    end
    wr_en_d[k] = 1'b0;
  endtask

  task automatic push_exp(input int k, input int first, input int n);
    for (int i = 0; i < n; i++) exp_q[k].push_back(8'(first + i));
  endtask

  // Wait for a request, ack it two cycles later, then measure the output burst.
  task automatic txn(input int k, input int exp_len, input int rdl);
    int t, first, cnt;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_w[k]) begin ok = 1'b1; break; end
    end
    chk(k, "req_seen", int'(ok), 1);
    if (!ok) return;
    chk(k, "tx_len", int'(len_w[k]), exp_len);
    step();
    step();
    ack_d[k] = 1'b1;
    t = cyc;
    step();
    ack_d[k] = 1'b0;
    @(negedge clk);
    chk(k, "req_release", int'(req_w[k]), 0);
    first = -1;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (valid_w[k]) begin
        if (first < 0) first = cyc;
        cnt++;
      end else if (first >= 0) begin
        break;
      end
    end
    chk(k, "first_valid_delay", first - t, rdl + 2);
    chk(k, "valid_run_len", cnt, exp_len);
  endtask

  task automatic wait_idle(input int k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy_w[k]) begin ok = 1'b1; break; end
    end
    chk(k, "busy_return_low", int'(ok), 1);
  endtask

  task automatic level_watch(input int k, input int exp_lvl, output int ov);
    ov = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (wr_en_d[k] && rd_w[k]) begin
        ov++;
        chk(k, "level_during_overlap", int'(lvl_w[k]), exp_lvl);
      end
    end
  endtask

  task automatic full_packet(input int k, input int rdl);
    int base;
    do_reset(k);
    push_exp(k, 1, 32);
    fork
      write_seq(k, 1, 40);
      txn(k, 32, rdl);
    join
    wait_idle(k);
    chk(k, "level_after_packet", int'(lvl_w[k]), 8);
    base = req_rise_w[k];
    repeat (40) step();
    chk(k, "no_second_req", req_rise_w[k] - base, 0);
    chk(k, "all_bytes_seen", exp_q[k].size(), 0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] e;
    int hi, lo, rd0, rr0, ov;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      rst_d[k] = 1'b1; wr_en_d[k] = 1'b0; wr_data_d[k] = 8'd0;
      flush_d[k] = 1'b0; ack_d[k] = 1'b0;
    end

    fork
      forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          if (valid_w[k]) begin
            if (exp_q[k].size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_byte inst%0d: got %0d expected no output", k, data_w[k]);
            end else begin
              e = exp_q[k].pop_front();
              chk(k, "payload_byte", int'(data_w[k]), int'(e));
            end
          end
        end
      end
    join_none

    repeat (3) step();
    for (int k = 0; k < 3; k++) rst_d[k] = 1'b0;
    @(negedge clk);
    chk(0, "rst_req", int'(req_w[0]), 0);
    chk(0, "rst_valid", int'(valid_w[0]), 0);
    chk(0, "rst_rd_en", int'(rd_w[0]), 0);
    chk(0, "rst_busy", int'(busy_w[0]), 0);
    chk(0, "rst_len", int'(len_w[0]), 0);
    chk(0, "rst_data", int'(data_w[0]), 0);
    chk(0, "rst_level", int'(lvl_w[0]), 0);

    // Full packet, RD_LATENCY=1, then RD_LATENCY=2.
    full_packet(0, 1);
    full_packet(1, 2);

    // Flush of a 5-byte partial packet.
    do_reset(0);
    push_exp(0, 101, 5);
    write_seq(0, 101, 5);
    flush_d[0] = 1'b1;
    step();
    flush_d[0] = 1'b0;
    txn(0, 5, 1);
    wait_idle(0);
    chk(0, "flush_level", int'(lvl_w[0]), 0);
    chk(0, "flush_bytes_seen", exp_q[0].size(), 0);

    // Concurrent write during READ; second packet continues at byte 33.
    do_reset(0);
    push_exp(0, 1, 64);
    fork
      write_seq(0, 1, 64);
      begin
        txn(0, 32, 1);
        txn(0, 32, 1);
      end
      level_watch(0, 36, ov);
    join
    chk(0, "overlap_cycles", ov, 28);
    wait_idle(0);
    chk(0, "concurrent_level_end", int'(lvl_w[0]), 0);
    chk(0, "concurrent_bytes_seen", exp_q[0].size(), 0);

    // Ack timeout with ACK_TIMEOUT=16.
    do_reset(2);
    rd0 = rd_cnt_w[2];
    write_seq(2, 1, 32);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_w[2]) begin ok = 1'b1; break; end
    end
    chk(2, "timeout_req_seen", int'(ok), 1);
    hi = 0;
    lo = 0;
    for (int i = 0; i < 100; i++) begin
      if (!req_w[2]) break;
      hi++;
      @(negedge clk);
    end
    for (int i = 0; i < 100; i++) begin
      if (req_w[2]) break;
      lo++;
      @(negedge clk);
    end
    chk(2, "timeout_req_high", hi, 16);
    chk(2, "timeout_req_low", lo, 3);
    chk(2, "timeout_no_reads", rd_cnt_w[2] - rd0, 0);
    chk(2, "timeout_level", int'(lvl_w[2]), 32);
    do_reset(2);

    // Reset after 10 bytes have been read.
    do_reset(0);
    push_exp(0, 1, 8);
    write_seq(0, 1, 32);
    rd0 = rd_cnt_w[0];
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_w[0]) begin ok = 1'b1; break; end
    end
    chk(0, "rstmid_req_seen", int'(ok), 1);
    step();
    step();
    ack_d[0] = 1'b1;
    step();
    ack_d[0] = 1'b0;
    repeat (9) step();
    rst_d[0] = 1'b1;
    step();
    rst_d[0] = 1'b0;
    @(negedge clk);
    chk(0, "rstmid_req", int'(req_w[0]), 0);
    chk(0, "rstmid_valid", int'(valid_w[0]), 0);
    chk(0, "rstmid_rd_en", int'(rd_w[0]), 0);
    chk(0, "rstmid_busy", int'(busy_w[0]), 0);
    chk(0, "rstmid_len", int'(len_w[0]), 0);
    chk(0, "rstmid_data", int'(data_w[0]), 0);
    chk(0, "rstmid_state", int'(st_w[0]), 0);
    chk(0, "rstmid_level", int'(lvl_w[0]), 0);
    chk(0, "rstmid_reads", rd_cnt_w[0] - rd0, 10);
    rr0 = req_rise_w[0];
    repeat (20) step();
    chk(0, "rstmid_no_more_reads", rd_cnt_w[0] - rd0, 10);
    chk(0, "rstmid_no_req", req_rise_w[0] - rr0, 0);
    chk(0, "rstmid_bytes_seen", exp_q[0].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
